// File: rtl/uio_bus_arbiter_if.sv
// Signal bundle between the uio pad arbiter, its internal requesters and the uio pads.
// Handshake: requester i raises req[i] and holds it for its whole tenure; gnt[i] high = it owns the pads; dropping req[i] ends the tenure.
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_dout;
  logic [8*NREQ-1:0] req_oe;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        din;
  logic              busy;
  logic              tmo;

  modport master (
    output ena, req, req_dout, req_oe, uio_in,
    input  uio_out, uio_oe, gnt, din, busy, tmo
  );

  modport slave (
    input  ena, req, req_dout, req_oe, uio_in,
    output uio_out, uio_oe, gnt, din, busy, tmo
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit uio pad bus, with an all-zero uio_oe turnaround on every owner change.
// Optional grant timeout enabled by defining UIO_ARB_TIMEOUT_EN.
module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uio_bus_arbiter_if.slave bus,
  output logic [1:0]       dbg_state_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_OWN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      din_q;
  logic [IW-1:0]   pick;
  logic            found;
  logic [IW-1:0]   ptr_next;

`ifdef UIO_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          tmo_q, tmo_d;
`endif

  // Cyclic search for the first active request starting at the round-robin pointer.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
        pick  = IW'((int'(ptr_q) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  assign ptr_next = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
`ifdef UIO_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.ena && |bus.req) begin
          w_d     = pick;
          cnt_d   = CW'(TURNAROUND - 1);
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (!bus.req[w_q] || !bus.ena) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_OWN;
          gnt_d   = NREQ'(1) << w_q;
`ifdef UIO_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OWN: begin
        if (!bus.req[w_q] || !bus.ena) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
`ifdef UIO_ARB_TIMEOUT_EN
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          tmo_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      din_q   <= '0;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      din_q   <= bus.uio_in;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Pads follow the owner combinationally, but only while the registered state says OWN.
  assign bus.uio_out = (state_q == S_OWN) ? bus.req_dout[8*int'(w_q) +: 8] : 8'h00;
  assign bus.uio_oe  = (state_q == S_OWN) ? bus.req_oe[8*int'(w_q) +: 8]   : 8'h00;
  assign bus.gnt     = gnt_q;
  assign bus.din     = din_q;
  assign bus.busy    = (state_q != S_IDLE);
`ifdef UIO_ARB_TIMEOUT_EN
  assign bus.tmo     = tmo_q;
`else
  assign bus.tmo     = 1'b0;
`endif
  assign dbg_state_o = state_q;
endmodule
